// File: rtl/dmem_pkg.sv
// Shared types, constants and the address-error rule for the data-memory responder.
`timescale 1ns/1ps
package dmem_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned BYTE_LANES = 4;
    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned CNT_W      = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Misaligned, or byte address beyond the 2**addr_w word array.
    function automatic logic addr_err(input logic [DATA_W-1:0] addr, input int unsigned addr_w);
        logic [DATA_W-1:0] hi;
        hi = addr >> (addr_w + 32'd2);
        return (addr[1:0] != 2'b00) || (hi != {DATA_W{1'b0}});
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Synchronous single-port word array with byte-lane write mask and registered read data.
`timescale 1ns/1ps
module dmem_array
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W = 10
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic                  kill_i,
    input  logic [BYTE_LANES-1:0] be_i,
    input  logic [ADDR_W-1:0]     addr_i,
    input  logic [DATA_W-1:0]     wdata_i,
    output logic [DATA_W-1:0]     rdata_o
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Byte-lane store; contents are deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (req_i && we_i && !kill_i) begin
            for (int k = 0; k < BYTE_LANES; k++) begin
                if (be_i[k]) begin
                    mem_q[addr_i][BYTE_W*k +: BYTE_W] <= wdata_i[BYTE_W*k +: BYTE_W];
                end
            end
        end
    end

    // Read data: zero for stores and faulting accesses, held between accesses.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= {DATA_W{1'b0}};
        end else if (req_i) begin
            if (we_i || kill_i) begin
                rdata_q <= {DATA_W{1'b0}};
            end else begin
                rdata_q <= mem_q[addr_i];
            end
        end else begin
            rdata_q <= rdata_q;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_memory_responder.sv
// Load/store data-memory responder: valid/ready request, fixed-latency single response pulse.
// Optional byte-lane stores are enabled by defining DMEM_BYTE_STROBE_EN.
`timescale 1ns/1ps
module data_memory_responder
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned LATENCY = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_write_i,
    input  logic [DATA_W-1:0]     req_addr_i,
    input  logic [DATA_W-1:0]     req_wdata_i,
`ifdef DMEM_BYTE_STROBE_EN
    input  logic [BYTE_LANES-1:0] req_be_i,
`endif
    output logic                  resp_valid_o,
    output logic [DATA_W-1:0]     resp_rdata_o,
    output logic                  resp_err_o,
    output logic                  busy_o
);

    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LATENCY - 1);

    state_e                  state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic                    write_q;
    logic [DATA_W-1:0]       addr_q;
    logic [DATA_W-1:0]       wdata_q;
    logic                    ready_q;
    logic                    valid_q;
    logic                    err_q;
    logic                    busy_q;
`ifdef DMEM_BYTE_STROBE_EN
    logic [BYTE_LANES-1:0]   be_q;
`endif

    logic                    accept_s;
    logic                    access_s;
    logic                    acc_write_s;
    logic [DATA_W-1:0]       acc_addr_s;
    logic [DATA_W-1:0]       acc_wdata_s;
    logic [BYTE_LANES-1:0]   acc_be_s;
    logic                    acc_err_s;

    assign accept_s = (state_q == ST_IDLE) && req_valid_i && ready_q;

    // The access fires on the edge that enters RESP; a reset on that edge drops it.
    assign access_s = !rst_i &&
                      ((accept_s && (LATENCY == 32'd1)) ||
                       ((state_q == ST_WAIT) && (cnt_q == 4'd1)));

    // With LATENCY==1 the access happens on the acceptance edge, so use the live inputs.
    always_comb begin
        acc_write_s = write_q;
        acc_addr_s  = addr_q;
        acc_wdata_s = wdata_q;
        if (state_q == ST_IDLE) begin
            acc_write_s = req_write_i;
            acc_addr_s  = req_addr_i;
            acc_wdata_s = req_wdata_i;
        end else begin
            acc_write_s = write_q;
            acc_addr_s  = addr_q;
            acc_wdata_s = wdata_q;
        end
    end

`ifdef DMEM_BYTE_STROBE_EN
    assign acc_be_s = (state_q == ST_IDLE) ? req_be_i : be_q;
`else
    assign acc_be_s = {BYTE_LANES{1'b1}};
`endif

    assign acc_err_s = addr_err(acc_addr_s, ADDR_W);

    // Request FSM with registered handshake and response flags.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            write_q <= 1'b0;
            addr_q  <= {DATA_W{1'b0}};
            wdata_q <= {DATA_W{1'b0}};
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
`ifdef DMEM_BYTE_STROBE_EN
            be_q    <= {BYTE_LANES{1'b0}};
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    valid_q <= 1'b0;
                    if (accept_s) begin
                        write_q <= req_write_i;
                        addr_q  <= req_addr_i;
                        wdata_q <= req_wdata_i;
`ifdef DMEM_BYTE_STROBE_EN
                        be_q    <= req_be_i;
`endif
                        cnt_q   <= LAT_M1;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        if (LATENCY == 32'd1) begin
                            state_q <= ST_RESP;
                            valid_q <= 1'b1;
                            err_q   <= acc_err_s;
                        end else begin
                            state_q <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q <= ST_RESP;
                        valid_q <= 1'b1;
                        err_q   <= acc_err_s;
                    end
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    dmem_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .req_i   (access_s),
        .we_i    (acc_write_s),
        .kill_i  (acc_err_s),
        .be_i    (acc_be_s),
        .addr_i  (acc_addr_s[ADDR_W+1:2]),
        .wdata_i (acc_wdata_s),
        .rdata_o (resp_rdata_o)
    );

    assign req_ready_o  = ready_q;
    assign resp_valid_o = valid_q;
    assign resp_err_o   = err_q;
    assign busy_o       = busy_q;

endmodule
